// File: rtl/iob_fifo_pkg.sv
// iob_fifo_pkg
// Helper functions and derived-width constants shared by the asymmetric
// synchronous FIFO and its lane controller. The DEF_* constants describe
// the default 32-bit write / 8-bit read configuration; modules recompute
// the same quantities from their own parameters with these functions.
package iob_fifo_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEF_W_DATA_W = 32;
  localparam int DEF_R_DATA_W = 8;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_MIN_W    = min_int(DEF_W_DATA_W, DEF_R_DATA_W);
  localparam int DEF_MAX_W    = max_int(DEF_W_DATA_W, DEF_R_DATA_W);
  localparam int DEF_R        = DEF_MAX_W / DEF_MIN_W;
  localparam int DEF_RATIO_W  = clog2(DEF_R);
  localparam int DEF_CAP      = (2 ** DEF_ADDR_W) * DEF_R;
  localparam int DEF_LVL_W    = DEF_ADDR_W + DEF_RATIO_W + 1;

endpackage

// File: rtl/bin_counter.sv
// bin_counter
// Free-running binary counter that advances by one when enabled and wraps
// modulo 2^W.
// Ports: clk, rst (async active-high), en_i (advance), cnt_o (count).
module bin_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + W'(1);
    else      cnt_d = cnt_q;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dp_ram.sv
// dp_ram
// Simple dual-port memory: one synchronous write port, one combinational
// read port. USE_RAM != 0 leaves the array unreset so it maps onto RAM;
// USE_RAM == 0 builds a reset register array.
// Ports: clk, rst, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module dp_ram #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int USE_RAM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  if (USE_RAM != 0) begin : g_ram
    logic rst_unused_s;
    assign rst_unused_s = rst;

    // Write port, no reset so the array stays RAM-mappable.
    always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
    end
  end else begin : g_reg
    // Write port on a reset register array.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
      end else if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iob_fifo_lane_ctrl.sv
// iob_fifo_lane_ctrl
// Lane counter plus a MAX_W buffer on the narrow side of the FIFO.
//   UNPACK == 0 (packer): each step stores narrow_i in the current lane;
//     the step on lane R-1 raises mem_en_o and wide_o carries the complete
//     word (buffered lanes with narrow_i on top) for the memory write.
//   UNPACK != 0 (unpacker): a step on lane 0 raises mem_en_o (memory
//     fetch) and latches wide_i; narrow_o is lane 0 of wide_i on lane 0,
//     otherwise the selected lane of the latched word.
// Lane order is little-endian. Ports: clk, rst, step_i, narrow_i, wide_i,
// wide_o, narrow_o, mem_en_o.
module iob_fifo_lane_ctrl
  import iob_fifo_pkg::*;
#(
  parameter int MIN_W  = 8,
  parameter int R      = 4,
  parameter int UNPACK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_i,
  input  logic [MIN_W-1:0]     narrow_i,
  input  logic [MIN_W*R-1:0]   wide_i,
  output logic [MIN_W*R-1:0]   wide_o,
  output logic [MIN_W-1:0]     narrow_o,
  output logic                 mem_en_o
);

  localparam int MAX_W   = MIN_W * R;
  localparam int RATIO_W = clog2(R);
  localparam logic [RATIO_W-1:0] LAST_LANE = RATIO_W'(R - 1);

  logic [RATIO_W-1:0] lane_q;
  logic [RATIO_W-1:0] lane_d;
  logic [MAX_W-1:0]   buf_q;
  logic [MAX_W-1:0]   buf_d;
  logic [MAX_W-1:0]   wide_s;
  logic               inputs_unused_s;

  // Each instance uses only one of the two data inputs.
  assign inputs_unused_s = ^{narrow_i, wide_i};

  // Next lane and buffer contents.
  always_comb begin
    lane_d = lane_q;
    buf_d  = buf_q;
    if (step_i) begin
      lane_d = lane_q + RATIO_W'(1);
      if (UNPACK != 0) begin
        if (lane_q == '0) buf_d = wide_i;
        else              buf_d = buf_q;
      end else begin
        buf_d[lane_q*MIN_W +: MIN_W] = narrow_i;
      end
    end else begin
      lane_d = lane_q;
      buf_d  = buf_q;
    end
  end

  // Lane counter and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      buf_q  <= '0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
    end
  end

  // Complete packed word: buffered lanes with the incoming word in the top lane.
  always_comb begin
    wide_s = buf_q;
    wide_s[MAX_W-1 -: MIN_W] = narrow_i;
  end

  assign wide_o   = wide_s;
  assign narrow_o = (lane_q == '0) ? wide_i[MIN_W-1:0] : buf_q[lane_q*MIN_W +: MIN_W];
  assign mem_en_o = (UNPACK != 0) ? (step_i & (lane_q == '0))
                                  : (step_i & (lane_q == LAST_LANE));

endmodule

// File: rtl/iob_sync_fifo_asym.sv
// iob_sync_fifo_asym
// Single-clock FIFO with independent write and read widths. Storage holds
// 2^ADDR_W words of MAX_W; a lane controller packs narrow writes or unpacks
// wide words for narrow reads. Occupancy (level) counts MIN_W units, and
// packed-but-uncommitted words are included in it.
// Ports: clk, rst (async active-high), w_en/w_data/w_full (write side),
// r_en/r_data/r_empty (read side, r_data registered, 1-cycle latency),
// level (occupancy in MIN_W units).
// Macro IOB_SFIFO_ALMOST_EN adds registered almost_full/almost_empty.
module iob_sync_fifo_asym
  import iob_fifo_pkg::*;
#(
  parameter int W_DATA_W         = 32,
  parameter int R_DATA_W         = 8,
  parameter int ADDR_W           = 4,
  parameter int USE_RAM          = 1,
  parameter int ALMOST_FULL_LVL  = 56,
  parameter int ALMOST_EMPTY_LVL = 8,
  localparam int MIN_W   = min_int(W_DATA_W, R_DATA_W),
  localparam int MAX_W   = max_int(W_DATA_W, R_DATA_W),
  localparam int R       = MAX_W / MIN_W,
  localparam int RATIO_W = clog2(R),
  localparam int CAP     = (2 ** ADDR_W) * R,
  localparam int LVL_W   = ADDR_W + RATIO_W + 1,
  localparam int WR      = W_DATA_W / MIN_W,
  localparam int RR      = R_DATA_W / MIN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [LVL_W-1:0]    level
`ifdef IOB_SFIFO_ALMOST_EN
  ,
  output logic                almost_full,
  output logic                almost_empty
`endif
);

  localparam logic [LVL_W-1:0] FULL_THR = LVL_W'(CAP - WR);
  localparam logic [LVL_W-1:0] WR_L     = LVL_W'(WR);
  localparam logic [LVL_W-1:0] RR_L     = LVL_W'(RR);

  logic                w_acc_s;
  logic                r_acc_s;
  logic [LVL_W-1:0]    level_q;
  logic [LVL_W-1:0]    level_d;
  logic [R_DATA_W-1:0] r_data_q;
  logic [R_DATA_W-1:0] r_data_d;
  logic [R_DATA_W-1:0] rd_word_s;
  logic                ram_we_s;
  logic [MAX_W-1:0]    ram_wdata_s;
  logic [MAX_W-1:0]    ram_rdata_s;
  logic                rptr_en_s;
  logic [ADDR_W-1:0]   wptr_s;
  logic [ADDR_W-1:0]   rptr_s;

  // Flags come straight from the registered level.
  assign w_full  = (level_q > FULL_THR);
  assign r_empty = (level_q < RR_L);
  assign w_acc_s = w_en & ~w_full;
  assign r_acc_s = r_en & ~r_empty;

  // Next occupancy; both terms apply on a simultaneous read and write.
  always_comb begin
    level_d = level_q;
    if (w_acc_s && r_acc_s) level_d = level_q + WR_L - RR_L;
    else if (w_acc_s)       level_d = level_q + WR_L;
    else if (r_acc_s)       level_d = level_q - RR_L;
    else                    level_d = level_q;
  end

  // Read data register: holds until the next accepted read.
  always_comb begin
    r_data_d = r_data_q;
    if (r_acc_s) r_data_d = rd_word_s;
    else         r_data_d = r_data_q;
  end

  // Occupancy and read data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      r_data_q <= '0;
    end else begin
      level_q  <= level_d;
      r_data_q <= r_data_d;
    end
  end

  assign level  = level_q;
  assign r_data = r_data_q;

  if (W_DATA_W < R_DATA_W) begin : g_pack
    logic [MIN_W-1:0] narrow_unused_s;

    iob_fifo_lane_ctrl #(.MIN_W(MIN_W), .R(R), .UNPACK(0)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .step_i   (w_acc_s),
      .narrow_i (w_data),
      .wide_i   ({MAX_W{1'b0}}),
      .wide_o   (ram_wdata_s),
      .narrow_o (narrow_unused_s),
      .mem_en_o (ram_we_s)
    );
    assign rd_word_s = ram_rdata_s;
    assign rptr_en_s = r_acc_s;
  end else if (W_DATA_W > R_DATA_W) begin : g_unpack
    logic [MAX_W-1:0] wide_unused_s;

    iob_fifo_lane_ctrl #(.MIN_W(MIN_W), .R(R), .UNPACK(1)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .step_i   (r_acc_s),
      .narrow_i ({MIN_W{1'b0}}),
      .wide_i   (ram_rdata_s),
      .wide_o   (wide_unused_s),
      .narrow_o (rd_word_s),
      .mem_en_o (rptr_en_s)
    );
    assign ram_wdata_s = w_data;
    assign ram_we_s    = w_acc_s;
  end else begin : g_equal
    assign ram_wdata_s = w_data;
    assign ram_we_s    = w_acc_s;
    assign rd_word_s   = ram_rdata_s;
    assign rptr_en_s   = r_acc_s;
  end

  bin_counter #(.W(ADDR_W)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (ram_we_s),
    .cnt_o (wptr_s)
  );

  bin_counter #(.W(ADDR_W)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rptr_en_s),
    .cnt_o (rptr_s)
  );

  dp_ram #(.DATA_W(MAX_W), .ADDR_W(ADDR_W), .USE_RAM(USE_RAM)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we_s),
    .waddr_i (wptr_s),
    .wdata_i (ram_wdata_s),
    .raddr_i (rptr_s),
    .rdata_o (ram_rdata_s)
  );

`ifdef IOB_SFIFO_ALMOST_EN
  localparam logic [LVL_W-1:0] AF_L = LVL_W'(ALMOST_FULL_LVL);
  localparam logic [LVL_W-1:0] AE_L = LVL_W'(ALMOST_EMPTY_LVL);

  logic almost_full_q;
  logic almost_empty_q;

  // Threshold flags, computed from the next level so they move with level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (level_d >= AF_L);
      almost_empty_q <= (level_d <= AE_L);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule
